div16u8_seq: RTL and testbench

// Sequential unsigned divider: inverse of the 8x8 unsigned multipliers in this library.

---
 rtl/div16u8_seq.sv | 111 +++++++++++
 tb/tb_div16u8_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div16u8_seq.sv
// Sequential unsigned divider: restoring radix-2, one quotient bit per clock, 2*DW-bit dividend / DW-bit divisor.
// Latency: 2*DW clocks from accept to out_valid; divide-by-zero goes straight to the result state.
// Backpressure: single op in flight; in_ready only when idle, result held stable until out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; A = dividend (2*DW), B = divisor (DW)
//   out_valid/out_ready   result handshake; Q = quotient (2*DW), R = remainder (DW)
//   OVF                   quotient needs more than DW bits
//   DZ                    divide by zero (Q = all ones, R = low DW bits of A)
module div16u8_seq #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] A,
  input  logic [DW-1:0]   B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] Q,
  output logic [DW-1:0]   R,
  output logic            OVF,
  output logic            DZ
);

  localparam int CW = $clog2(2*DW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [2*DW-1:0] work;      // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [DW-1:0]   div;
  logic [DW-1:0]   prem;      // partial remainder; always < div after each step
  logic [CW-1:0]   cnt;

  logic [DW:0]     shifted;   // one extra bit holds the carry before the trial subtract
  logic            no_borrow;
  logic [DW-1:0]   prem_step;
  logic [2*DW-1:0] work_step;

  // One restoring step: bring in the next dividend bit and trial-subtract the divisor.
  // The difference is always < div, so it fits back into DW bits.
  always_comb begin
    shifted   = {prem, work[2*DW-1]};
    no_borrow = (shifted >= {1'b0, div});
    prem_step = no_borrow ? DW'(shifted - {1'b0, div}) : shifted[DW-1:0];
    work_step = {work[2*DW-2:0], no_borrow};
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_nxt = (B == '0) ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      div   <= '0;
      prem  <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      OVF   <= 1'b0;
      DZ    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= A;
            div  <= B;
            prem <= '0;
            cnt  <= CW'(2*DW-1);
            if (B == '0) begin
              Q   <= '1;
              R   <= A[DW-1:0];
              OVF <= 1'b1;
              DZ  <= 1'b1;
            end
          end
        end
        BUSY: begin
          work <= work_step;
          prem <= prem_step;
          cnt  <= cnt - CW'(1);
          // Outputs only change when the last bit is produced, so the
          // previous result stays visible while this one is computed.
          if (cnt == '0) begin
            Q   <= work_step;
            R   <= prem_step;
            OVF <= |work_step[2*DW-1:DW];
            DZ  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div16u8_seq.sv
module tb_div16u8_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        OVF;
  logic        DZ;

  always #5 clk = ~clk;

  div16u8_seq #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .OVF(OVF), .DZ(DZ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic ovf, output logic dz);
    if (b == 0) begin
      q = 16'hFFFF; r = a[7:0]; ovf = 1'b1; dz = 1'b1;
    end else begin
      q = a / b; r = 8'(a % b); ovf = (q > 16'd255); dz = 1'b0;
    end
  endtask

  // One full transaction: handshake in, wait for result, hold under backpressure, handshake out.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input logic eo, input logic ed, input int hold);
    int w;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    // Scramble operands after accept: they must be ignored.
    in_valid = 1'b0; A = 16'($urandom); B = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("out_valid_timeout", out_valid, 1);
    if (b != 0) chk("latency", lat, 16);
    else        chk("dz_latency_le1", (lat <= 1), 1);
    chk("in_ready_done", in_ready, 0);
    chk("Q", Q, eq);
    chk("R", R, er);
    chk("OVF", OVF, eo);
    chk("DZ", DZ, ed);
    if (b != 0) begin
      chk("identity", 32'(Q) * 32'(b) + 32'(R), 32'(a));
      chk("r_lt_b", (R < b), 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_Q", Q, eq);
      chk("bp_R", R, er);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_Q_hold", Q, eq);
    chk("post_R_hold", R, er);
    out_ready = 1'b0;
  endtask

  task automatic run_rand(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq; logic [7:0] er; logic eo, ed;
    ref_div(a, b, eq, er, eo, ed);
    run_op(a, b, eq, er, eo, ed, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   pulses[$];
    int   cyc;

    tbl[0] = '{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 1'b0, 0};
    tbl[1] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b1, 1'b0, 0};
    tbl[2] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1'b1, 0};
    tbl[3] = '{16'h00FE, 8'h0F, 16'h0010, 8'h0E, 1'b0, 1'b0, 5};
    tbl[4] = '{16'h8000, 8'h03, 16'h2AAA, 8'h02, 1'b1, 1'b0, 0};
    tbl[5] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b0, 0};
    tbl[6] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b1, 1'b0, 2};
    tbl[7] = '{16'h7FFF, 8'h80, 16'h00FF, 8'h7F, 1'b0, 1'b0, 0};
    tbl[8] = '{16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 1'b0, 0};
    tbl[9] = '{16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, 1'b0, 0};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_OVF", OVF, 0);
    chk("rst_DZ", DZ, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].ovf, tbl[i].dz, tbl[i].hold);

    // Reset in the middle of a division aborts it
    @(negedge clk);
    in_valid = 1'b1; A = 16'h8000; B = 8'h03;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_Q", Q, 0);
    chk("mid_rst_R", R, 0);
    chk("mid_rst_OVF", OVF, 0);
    chk("mid_rst_DZ", DZ, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("aborted_no_result", out_valid, 0);
    end
    run_op(16'h8000, 8'h03, 16'h2AAA, 8'h02, 1'b1, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high: one op every 18 cycles
    @(negedge clk);
    in_valid = 1'b1; A = 16'd100; B = 8'd3; out_ready = 1'b1;
    cyc = 0;
    repeat (60) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        pulses.push_back(cyc);
        chk("b2b_Q", Q, 16'd33);
        chk("b2b_R", R, 8'd1);
      end
    end
    in_valid = 1'b0;
    chk("b2b_pulse_count_ge3", (pulses.size() >= 3), 1);
    if (pulses.size() >= 3) begin
      chk("b2b_spacing0", pulses[1] - pulses[0], 18);
      chk("b2b_spacing1", pulses[2] - pulses[1], 18);
    end
    repeat (25) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_idle", in_ready, 1);

    // Products of 8x8 multiplies read back exactly
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a8, b8;
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(1, 255));
      run_op(16'(a8) * 16'(b8), b8, 16'(a8), 8'h00, 1'b0, 1'b0, 0);
    end

    // Random operands against the reference model (includes occasional B==0)
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = (i % 50 == 0) ? 8'h00 : 8'($urandom);
      run_rand(ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
